// File: rtl/hazard_controller_pkg.sv
// Shared RISC-V opcode constants and hazard-controller FSM encodings.
package hazard_controller_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_MUL  = 7'h01;
    localparam logic [2:0] FUNCT3_MUL  = 3'd0;
    localparam logic [4:0] REG_X0      = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_controller_operand_use_decoder.sv
// Combinational decode of which source registers an instruction reads, and MUL detection.
module operand_use_decoder
    import hazard_controller_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        is_mul
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_rd_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    // rd never takes part in hazard detection on the decode side
    assign unused_rd_bits = ^instr[11:7];

    assign rs1_used = (opcode == OPC_OP)    || (opcode == OPC_OP_IMM) ||
                      (opcode == OPC_LOAD)  || (opcode == OPC_STORE)  ||
                      (opcode == OPC_BRANCH)|| (opcode == OPC_JALR);
    assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign is_mul   = (opcode == OPC_OP) && (funct3 == FUNCT3_MUL) && (funct7 == FUNCT7_MUL);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing: load-use bubbles, multi-cycle MUL occupancy and branch wrong-path flush.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dec_instr,
    input  logic        ex_dest_enable,
    input  logic [4:0]  ex_dest_number,
    input  logic        ex_is_load,
    input  logic        branch_taken,
    output logic        fetch_stall,
    output logic        kill_instr,
    output logic        mul_busy,
    output logic [1:0]  state,
    output logic [31:0] bubble_count
);

    hz_state_t   state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] bubble_count_reg;

    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used, is_mul;
    logic       load_use_hit;

    operand_use_decoder u_decoder (
        .instr    (dec_instr),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .is_mul   (is_mul)
    );

    assign load_use_hit = ex_is_load && ex_dest_enable && (ex_dest_number != REG_X0) &&
                          ((rs1_used && (rs1 == ex_dest_number)) ||
                           (rs2_used && (rs2 == ex_dest_number)));

    always_comb begin
        fetch_stall = 1'b0;
        kill_instr  = 1'b0;
        mul_busy    = 1'b0;
        state_next  = state_reg;
        cnt_next    = cnt_reg;

        // A taken branch redirects fetch, so it overrides any occupancy in progress
        if (branch_taken) begin
            kill_instr = 1'b1;
            if (FLUSH_DEPTH == 1) begin
                state_next = ST_RUN;
                cnt_next   = 4'd0;
            end else begin
                state_next = ST_FLUSH;
                cnt_next   = 4'(FLUSH_DEPTH - 1);
            end
        end else begin
            case (state_reg)
                ST_MUL_WAIT: begin
                    fetch_stall = 1'b1;
                    kill_instr  = 1'b1;
                    mul_busy    = 1'b1;
                    if (cnt_reg == 4'd1) begin
                        state_next = ST_RUN;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                ST_FLUSH: begin
                    kill_instr = 1'b1;
                    if (cnt_reg == 4'd1) begin
                        state_next = ST_RUN;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                default: begin
                    if (load_use_hit) begin
                        fetch_stall = 1'b1;
                        kill_instr  = 1'b1;
                    end else if (is_mul && (MUL_LATENCY > 1)) begin
                        state_next = ST_MUL_WAIT;
                        cnt_next   = 4'(MUL_LATENCY - 1);
                    end
                end
            endcase
        end

        if (reset) begin
            fetch_stall = 1'b0;
            kill_instr  = 1'b0;
            mul_busy    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_RUN;
            cnt_reg          <= 4'd0;
            bubble_count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (kill_instr) begin
                bubble_count_reg <= bubble_count_reg + 32'd1;
            end
        end
    end

    assign state        = state_reg;
    assign bubble_count = bubble_count_reg;

endmodule
